// File: rtl/ave8_pkg.sv
// Shared definitions for the ave8 moving-average block and its stream sequencer.
//   ave8_state_t : sequencer state encoding (FILL / RUN / FLUSH)
//   AVE8_WIN     : window depth (tap count of the ave8 datapath)
//   AVE8_DW      : sample/result width of the ave8 datapath
//   ENA_ALL/NONE : datapath enable patterns (shift all taps / hold)
package ave8_pkg;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } ave8_state_t;

    localparam int         AVE8_WIN = 8;
    localparam int         AVE8_DW  = 8;
    localparam logic [7:0] ENA_ALL  = 8'hFF;
    localparam logic [7:0] ENA_NONE = 8'h00;

endpackage

// File: rtl/ave8_ctrl.sv
// Stream sequencer for the ave8 8-tap moving-average datapath.
// Accepts samples on a valid/ready input, steers them into the datapath, tracks
// window fill and only reports averages once the window holds WIN real samples.
// A clear request flushes the datapath window by shifting in WIN zero samples.
//
// Ports
//   CLOCK, RESET         rising-edge clock, synchronous active-high reset
//   s_valid/s_ready/s_data  sample input stream (s_ready is combinational)
//   clr                  flush request pulse
//   m_valid/m_ready/m_data  full-window average output stream
//   busy                 high while the window is being flushed
//   fill_cnt             accepted samples since reset/flush, saturates at WIN
//   dp_in0/dp_enable     drive the ave8 sample input and shift enable
//   dp_ret               registered average returned by ave8
module ave8_ctrl
    import ave8_pkg::*;
#(
    parameter int DATA_W = AVE8_DW,
    parameter int WIN    = AVE8_WIN,
    parameter int CNT_W  = 4
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              clr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic [CNT_W-1:0]  fill_cnt,
    output logic [DATA_W-1:0] dp_in0,
    output logic [DATA_W-1:0] dp_enable,
    input  logic [DATA_W-1:0] dp_ret
);

    localparam logic [CNT_W-1:0]  WIN_C  = CNT_W'(WIN);
    localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(WIN - 1);
    localparam logic [DATA_W-1:0] ENA_ON  = DATA_W'(ENA_ALL);
    localparam logic [DATA_W-1:0] ENA_OFF = DATA_W'(ENA_NONE);

    ave8_state_t      state_q, state_d;
    logic [CNT_W-1:0] flush_cnt;
    logic             in_flush;
    logic             acc;

    assign in_flush = (state_q == ST_FLUSH);

    // clr wins over s_valid; a held result blocks new samples so the
    // datapath output (m_data) cannot change under an unconsumed m_valid.
    assign s_ready = ~in_flush & ~clr & (~m_valid | m_ready);
    assign acc     = s_valid & s_ready;
    assign busy    = in_flush;
    assign m_data  = dp_ret;

    // Datapath steering: flush shifts zeros every cycle, otherwise shift only
    // on an accepted sample so ave8 holds its sum in between.
    always_comb begin
        dp_enable = ENA_OFF;
        dp_in0    = '0;
        if (!RESET) begin
            if (in_flush) begin
                dp_enable = ENA_ON;
            end else begin
                dp_in0 = s_data;
                if (acc) dp_enable = ENA_ON;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FILL: begin
                if (clr)                              state_d = ST_FLUSH;
                else if (acc && fill_cnt == LAST_C)   state_d = ST_RUN;
            end
            ST_RUN: begin
                if (clr) state_d = ST_FLUSH;
            end
            ST_FLUSH: begin
                // a repeated clr keeps us here with the counter restarted
                if (!clr && flush_cnt == LAST_C) state_d = ST_FILL;
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q   <= ST_FILL;
            fill_cnt  <= '0;
            flush_cnt <= '0;
            m_valid   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clr) begin
                // pending result belongs to the discarded window
                fill_cnt  <= '0;
                flush_cnt <= '0;
                m_valid   <= 1'b0;
            end else begin
                if (in_flush)
                    flush_cnt <= (flush_cnt == LAST_C) ? '0 : flush_cnt + 1'b1;

                if (acc && fill_cnt != WIN_C)
                    fill_cnt <= fill_cnt + 1'b1;

                // fill_cnt >= WIN-1 here means this sample completes (or
                // follows completion of) a full window
                if (acc && fill_cnt >= LAST_C) m_valid <= 1'b1;
                else if (m_ready)              m_valid <= 1'b0;
            end
        end
    end

endmodule
